// File: rtl/perf_pkg.sv
// Shared constants and state type for the performance counter unit.
// Counter index map, opcode classes and the RUN/HALTED state encoding.
package perf_pkg;

  localparam int CNT_TC  = 0;
  localparam int CNT_R   = 1;
  localparam int CNT_I   = 2;
  localparam int CNT_J   = 3;
  localparam int CNT_EV0 = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/perf_ctr.sv
// Single statistics counter: clear, hold, increment, sticky overflow.
// SAT=1 pins the value at all-ones; SAT=0 wraps to zero.
module perf_ctr #(
  parameter int CNT_W = 32,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  // clr wins over everything; hold freezes the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc && !hold) begin
      if (&cnt) begin
        ovf <= 1'b1;
        cnt <= (SAT != 0) ? cnt : '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// CPU statistics counters: cycles, R/I/J retirements and NUM_EV events.
// Define PERF_SNAPSHOT_EN to read out through a snapshot shadow bank.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int NUM_EV = 4,
  parameter int SAT    = 0,
  localparam int NCNT  = NUM_EV + 4,
  localparam int SEL_W = $clog2(NUM_EV + 4)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ret_vld,
  input  logic [5:0]        ret_op,
  input  logic [NUM_EV-1:0] ev,
  input  logic              halt,
  input  logic              clr,
  input  logic              snap,
  input  logic [SEL_W-1:0]  sel,
  output logic [CNT_W-1:0]  rdata,
  output logic [NCNT-1:0]   ovf,
  output logic [CNT_W-1:0]  statTC,
  output logic [CNT_W-1:0]  statR,
  output logic [CNT_W-1:0]  statI,
  output logic [CNT_W-1:0]  statJ,
  output logic              halted
);

  state_t state_q, state_d;
  logic hold;
  logic is_r, is_j;
  logic [NCNT-1:0] inc;
  logic [CNT_W-1:0] cnt [NCNT];
  logic [CNT_W-1:0] src [NCNT];
  logic [CNT_W-1:0] tab [2**SEL_W];

  assign is_r = (ret_op == OP_RTYPE);
  assign is_j = (ret_op == OP_J) || (ret_op == OP_JAL);

  // per-counter increment strobes for this cycle
  always_comb begin
    inc = '0;
    inc[CNT_TC] = 1'b1;
    inc[CNT_R]  = ret_vld && is_r;
    inc[CNT_I]  = ret_vld && !is_r && !is_j;
    inc[CNT_J]  = ret_vld && is_j;
    inc[NCNT-1:CNT_EV0] = ev;
  end

  // run/halted state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // halt latches until clr; counts of the halting cycle still land
  always_comb begin
    state_d = state_q;
    if (clr)
      state_d = ST_RUN;
    else if (state_q == ST_RUN && halt)
      state_d = ST_HALTED;
  end

  assign hold   = (state_q == ST_HALTED);
  assign halted = hold;

  for (genvar g = 0; g < NCNT; g++) begin : g_ctr
    perf_ctr #(
      .CNT_W(CNT_W),
      .SAT  (SAT)
    ) u_ctr (
      .clk  (clk),
      .reset(reset),
      .inc  (inc[g]),
      .clr  (clr),
      .hold (hold),
      .cnt  (cnt[g]),
      .ovf  (ovf[g])
    );
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow [NCNT];

  for (genvar g = 0; g < NCNT; g++) begin : g_shd
    // shadow copy captures pre-increment values, in any state
    always_ff @(posedge clk or posedge reset) begin
      if (reset)     shadow[g] <= '0;
      else if (clr)  shadow[g] <= '0;
      else if (snap) shadow[g] <= cnt[g];
    end
    assign src[g] = shadow[g];
  end
`else
  logic unused_snap;
  assign unused_snap = snap;

  for (genvar g = 0; g < NCNT; g++) begin : g_src
    assign src[g] = cnt[g];
  end
`endif

  // pad the readout table so out-of-range indices read zero
  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_tab
    if (g < NCNT) begin : g_live
      assign tab[g] = src[g];
    end else begin : g_zero
      assign tab[g] = '0;
    end
  end

  // registered indexed readout, one cycle behind sel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= tab[sel];
  end

  assign statTC = cnt[CNT_TC];
  assign statR  = cnt[CNT_R];
  assign statI  = cnt[CNT_I];
  assign statJ  = cnt[CNT_J];

endmodule
